ultra_mem_resp: RTL and testbench
=================================

ULTRA_MEM_RESP -- requirements
Module: ultra_mem_resp

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- DATA_W, 16, word width
- ADDR_W, 8, address width
- DEPTH, 256, implemented words; DEPTH <= 2^ADDR_W
- LATENCY, 2, wait cycles between accept and response, range 0..15
REQ-002 SHALL have one clock, clk; reset is synchronous and active-high, rst.
REQ-003 SHALL have ports, one per line: name  direction  width  meaning.
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  initiator presents request
- req_ready  out  1  responder can accept
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response presented
- rsp_ready  in  1  initiator takes response
- rsp_rdata  out  DATA_W  read data, or write echo
- rsp_err  out  1  address >= DEPTH

Function
REQ-004 SHALL implement the FSM states IDLE, WAIT and RESP; only one request outstanding.
REQ-005 SHALL drive req_ready=1 in IDLE only, combinationally from state; it SHALL NOT depend on req_valid.
REQ-006 SHALL accept a request on a clock edge with req_valid&&req_ready and capture we, addr and wdata into holding registers; inputs are don't-care afterwards.
REQ-007 On accept, SHALL go to WAIT and load counter=LATENCY-1; if LATENCY=0, SHALL go directly to RESP.
REQ-008 In WAIT, SHALL decrement the counter each cycle and go to RESP on the edge where counter==0; total accept-to-rsp_valid delay is LATENCY+1 edges.
REQ-009 On the transition into RESP, SHALL commit the operation exactly once.
- Read: rsp_rdata <= MEM[addr]
- Write: MEM[addr] <= wdata and rsp_rdata <= wdata
REQ-010 If the captured addr >= DEPTH, SHALL perform no array access, set rsp_err=1 and set rsp_rdata=0; otherwise rsp_err=0.
REQ-011 In RESP, SHALL hold rsp_valid=1 and keep rsp_rdata and rsp_err stable until rsp_valid&&rsp_ready, then return to IDLE on that edge.
REQ-012 SHALL drive rsp_valid=0 outside RESP; rsp_rdata and rsp_err hold their last values.
REQ-013 Minimum transaction spacing SHALL be LATENCY+2 cycles; a req_valid held across RESP SHALL be accepted in the following IDLE cycle.
REQ-014 A read SHALL return the data of any write whose response completed earlier.
REQ-015 Array contents SHALL be uninitialised (X) in RTL; the bench preloads through writes.

Reset
REQ-016 When rst=1 at an edge, SHALL go to IDLE and clear to 0: counter, rsp_valid, rsp_rdata, rsp_err and the holding registers; req_ready=1 in the next cycle.
REQ-017 Reset during WAIT SHALL discard the pending write; the array SHALL be unchanged.
REQ-018 Reset during RESP SHALL drop rsp_valid without a handshake; any already-committed write SHALL persist.
REQ-019 The array SHALL NOT be cleared by rst.
REQ-020 rst SHALL take priority over simultaneous req or rsp handshakes.

Verification
REQ-021 Write then read, LATENCY=2: write addr 5 data 0x0003 -> rsp_valid 3 edges after accept, rsp_rdata=0x0003, rsp_err=0; read addr 5 -> rsp_rdata=0x0003.
REQ-022 Response back-pressure: hold rsp_ready=0 for 4 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; release -> IDLE on the next edge.
REQ-023 LATENCY=0: read addr 4 (preloaded 0x0001) -> rsp_valid on the edge after accept; sustained req_valid gives one transaction every 2 cycles.
REQ-024 DEPTH=16: write addr 20 data 0xBEEF -> rsp_err=1, rsp_rdata=0, and a read of addr 4 is unchanged.
REQ-025 Reset during WAIT of a write to addr 7 data 0x1234 (addr 7 previously 0x0042) -> IDLE, outputs 0, and a later read of addr 7 returns 0x0042.
REQ-026 Back-to-back requests with rsp_ready=1, LATENCY=1: writes to addrs 0..3 with data 1..4, then reads 0..3 -> responses 1,2,3,4 in order, with exactly one response per accept.

Source files
------------

// File: rtl/ultra_mem_resp.sv
// Single-outstanding memory responder: accepts one request, waits LATENCY cycles,
// commits the read/write once and holds the response until the initiator takes it.
module ultra_mem_resp #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              hold_we;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              commit;
  logic              op_we;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic              op_in_range;
  logic [IDX_W-1:0]  op_idx;

  assign req_ready = (state == IDLE);

  // Zero-latency commits straight from the request bus; otherwise from the holding registers.
  assign op_we       = (state == IDLE) ? req_we    : hold_we;
  assign op_addr     = (state == IDLE) ? req_addr  : hold_addr;
  assign op_wdata    = (state == IDLE) ? req_wdata : hold_wdata;
  assign op_in_range = (32'(op_addr) < DEPTH);
  assign op_idx      = op_addr[IDX_W-1:0];

  // Next-state and strobe decode
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_nxt = RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Holding registers, wait counter and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      hold_we    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= (state_nxt == RESP);
      if (accept) begin
        hold_we    <= req_we;
        hold_addr  <= req_addr;
        hold_wdata <= req_wdata;
        cnt        <= CNT_W'(LATENCY - 1);
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (commit) begin
        rsp_err <= ~op_in_range;
        if (!op_in_range) rsp_rdata <= '0;
        else if (op_we)   rsp_rdata <= op_wdata;
        else              rsp_rdata <= mem[op_idx];
      end
    end
  end

  // Storage array is never reset; a reset edge suppresses the commit.
  always_ff @(posedge clk) begin
    if (!rst && commit && op_we && op_in_range) mem[op_idx] <= op_wdata;
  end

endmodule

// File: tb/tb_ultra_mem_resp.sv
// Directed bench for ultra_mem_resp: three instances cover LATENCY=2/DEPTH=256,
// LATENCY=0/DEPTH=16 and LATENCY=1/DEPTH=256.
module tb_ultra_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        rv   [3];
  logic        rqr  [3];
  logic        rw   [3];
  logic [7:0]  ra   [3];
  logic [15:0] rwd  [3];
  logic        rspv [3];
  logic        rr   [3];
  logic [15:0] rdat [3];
  logic        rerr [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ultra_mem_resp #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rqr[0]), .req_we(rw[0]),
    .req_addr(ra[0]), .req_wdata(rwd[0]), .rsp_valid(rspv[0]), .rsp_ready(rr[0]),
    .rsp_rdata(rdat[0]), .rsp_err(rerr[0]));

  ultra_mem_resp #(.DATA_W(16), .ADDR_W(8), .DEPTH(16), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rqr[1]), .req_we(rw[1]),
    .req_addr(ra[1]), .req_wdata(rwd[1]), .rsp_valid(rspv[1]), .rsp_ready(rr[1]),
    .rsp_rdata(rdat[1]), .rsp_err(rerr[1]));

  ultra_mem_resp #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(rv[2]), .req_ready(rqr[2]), .req_we(rw[2]),
    .req_addr(ra[2]), .req_wdata(rwd[2]), .rsp_valid(rspv[2]), .rsp_ready(rr[2]),
    .rsp_rdata(rdat[2]), .rsp_err(rerr[2]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait for req_ready, pass the accept edge, then drop req_valid.
  task automatic issue(input int d, input logic we, input logic [7:0] a, input logic [15:0] wd);
    int n;
    n = 0;
    rv[d] = 1'b1; rw[d] = we; ra[d] = a; rwd[d] = wd;
    while (!rqr[d] && n < 50) begin step(); n++; end
    if (!rqr[d]) begin
      tests++; fails++;
      $display("FAIL issue_timeout dut%0d: req_ready=%b required 1", d, rqr[d]);
    end
    step();
    rv[d] = 1'b0;
  endtask

  // Count edges from accept (inclusive) until rsp_valid shows.
  task automatic await_rsp(input int d, output logic [15:0] data, output logic err, output int lat);
    lat = 1;
    while (!rspv[d] && lat < 50) begin step(); lat++; end
    if (!rspv[d]) begin
      tests++; fails++;
      $display("FAIL rsp_timeout dut%0d: rsp_valid=%b required 1", d, rspv[d]);
    end
    data = rdat[d];
    err  = rerr[d];
  endtask

  task automatic txn(input int d, input logic we, input logic [7:0] a, input logic [15:0] wd,
                     output logic [15:0] data, output logic err, output int lat);
    issue(d, we, a, wd);
    await_rsp(d, data, err, lat);
    if (rr[d]) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      tests++; if (rqr[d] !== 1'b1) begin fails++; $display("FAIL reset_req_ready dut%0d: got %b want 1", d, rqr[d]); end
      tests++; if (rspv[d] !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid dut%0d: got %b want 0", d, rspv[d]); end
      tests++; if (rdat[d] !== 16'h0) begin fails++; $display("FAIL reset_rdata dut%0d: got %h want 0000", d, rdat[d]); end
      tests++; if (rerr[d] !== 1'b0) begin fails++; $display("FAIL reset_err dut%0d: got %b want 0", d, rerr[d]); end
    end
  endtask

  task automatic test_write_read();
    logic [15:0] data; logic err; int lat;
    txn(0, 1'b1, 8'd5, 16'h0003, data, err, lat);
    tests++; if (lat != 3) begin fails++; $display("FAIL wr_latency: got %0d want 3", lat); end
    tests++; if (data !== 16'h0003) begin fails++; $display("FAIL wr_echo: got %h want 0003", data); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL wr_err: got %b want 0", err); end
    txn(0, 1'b0, 8'd5, 16'hFFFF, data, err, lat);
    tests++; if (lat != 3) begin fails++; $display("FAIL rd_latency: got %0d want 3", lat); end
    tests++; if (data !== 16'h0003) begin fails++; $display("FAIL rd_data: got %h want 0003", data); end
  endtask

  task automatic test_backpressure();
    logic [15:0] data; logic err; int lat;
    rr[0] = 1'b0;
    issue(0, 1'b0, 8'd5, 16'h0);
    await_rsp(0, data, err, lat);
    tests++; if (data !== 16'h0003) begin fails++; $display("FAIL bp_data: got %h want 0003", data); end
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (rspv[0] !== 1'b1 || rdat[0] !== 16'h0003 || rqr[0] !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold cyc%0d: valid=%b data=%h ready=%b want 1/0003/0", i, rspv[0], rdat[0], rqr[0]);
      end
    end
    rr[0] = 1'b1;
    step();
    tests++;
    if (rspv[0] !== 1'b0 || rqr[0] !== 1'b1) begin
      fails++; $display("FAIL bp_release: valid=%b ready=%b want 0/1", rspv[0], rqr[0]);
    end
  endtask

  task automatic test_latency0();
    logic [15:0] data; logic err; int lat; int na; int nr; int bad;
    txn(1, 1'b1, 8'd4, 16'h0001, data, err, lat);
    txn(1, 1'b0, 8'd4, 16'h0, data, err, lat);
    tests++; if (lat != 1) begin fails++; $display("FAIL l0_latency: got %0d want 1", lat); end
    tests++; if (data !== 16'h0001) begin fails++; $display("FAIL l0_rdata: got %h want 0001", data); end
    na = 0; nr = 0; bad = 0;
    rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 8'd4;
    for (int i = 0; i < 8; i++) begin
      if (rv[1] && rqr[1]) na++;
      if (rspv[1] && rr[1]) begin nr++; if (rdat[1] !== 16'h0001) bad++; end
      step();
    end
    rv[1] = 1'b0;
    tests++; if (na != 4) begin fails++; $display("FAIL l0_sustain_accepts: got %0d want 4", na); end
    tests++; if (nr != 4) begin fails++; $display("FAIL l0_sustain_rsps: got %0d want 4", nr); end
    tests++; if (bad != 0) begin fails++; $display("FAIL l0_sustain_data: %0d bad words want 0", bad); end
  endtask

  task automatic test_out_of_range();
    logic [15:0] data; logic err; int lat;
    txn(1, 1'b1, 8'd20, 16'hBEEF, data, err, lat);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL oor_err: got %b want 1", err); end
    tests++; if (data !== 16'h0000) begin fails++; $display("FAIL oor_rdata: got %h want 0000", data); end
    txn(1, 1'b0, 8'd4, 16'h0, data, err, lat);
    tests++; if (data !== 16'h0001 || err !== 1'b0) begin fails++; $display("FAIL oor_addr4: got %h/%b want 0001/0", data, err); end
    txn(1, 1'b1, 8'd15, 16'h00AA, data, err, lat);
    txn(1, 1'b0, 8'd15, 16'h0, data, err, lat);
    tests++; if (data !== 16'h00AA || err !== 1'b0) begin fails++; $display("FAIL edge_addr15: got %h/%b want 00aa/0", data, err); end
    txn(1, 1'b0, 8'd16, 16'h0, data, err, lat);
    tests++; if (data !== 16'h0000 || err !== 1'b1) begin fails++; $display("FAIL edge_addr16: got %h/%b want 0000/1", data, err); end
  endtask

  task automatic test_reset_in_wait();
    logic [15:0] data; logic err; int lat;
    txn(0, 1'b1, 8'd7, 16'h0042, data, err, lat);
    issue(0, 1'b1, 8'd7, 16'h1234);
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if (rqr[0] !== 1'b1 || rspv[0] !== 1'b0 || rdat[0] !== 16'h0 || rerr[0] !== 1'b0) begin
      fails++;
      $display("FAIL wait_reset_outs: ready=%b valid=%b data=%h err=%b want 1/0/0000/0", rqr[0], rspv[0], rdat[0], rerr[0]);
    end
    txn(0, 1'b0, 8'd7, 16'h0, data, err, lat);
    tests++; if (data !== 16'h0042) begin fails++; $display("FAIL wait_reset_mem: got %h want 0042", data); end
  endtask

  task automatic test_reset_in_resp();
    logic [15:0] data; logic err; int lat;
    rr[0] = 1'b0;
    issue(0, 1'b1, 8'd9, 16'h5555);
    await_rsp(0, data, err, lat);
    rst = 1'b1;
    step();
    rst = 1'b0;
    rr[0] = 1'b1;
    tests++;
    if (rspv[0] !== 1'b0 || rqr[0] !== 1'b1) begin
      fails++; $display("FAIL resp_reset: valid=%b ready=%b want 0/1", rspv[0], rqr[0]);
    end
    txn(0, 1'b0, 8'd9, 16'h0, data, err, lat);
    tests++; if (data !== 16'h5555) begin fails++; $display("FAIL resp_reset_mem: got %h want 5555", data); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got [8];
    logic [15:0] want;
    int k; int na; int nr; logic acc; logic rsp;
    k = 0; na = 0; nr = 0;
    for (int cyc = 0; cyc < 100 && nr < 8; cyc++) begin
      if (k < 8) begin
        rv[2] = 1'b1; rw[2] = (k < 4); ra[2] = 8'(k % 4); rwd[2] = 16'(k + 1);
      end else begin
        rv[2] = 1'b0;
      end
      acc = rv[2] && rqr[2];
      rsp = rspv[2] && rr[2];
      if (rsp) got[nr] = rdat[2];
      step();
      if (acc) begin k++; na++; end
      if (rsp) nr++;
    end
    rv[2] = 1'b0;
    tests++; if (na != 8 || nr != 8) begin fails++; $display("FAIL b2b_counts: accepts=%0d rsps=%0d want 8/8", na, nr); end
    for (int i = 0; i < 8 && i < nr; i++) begin
      want = (i < 4) ? 16'(i + 1) : 16'(i - 3);
      tests++; if (got[i] !== want) begin fails++; $display("FAIL b2b_rsp%0d: got %h want %h", i, got[i], want); end
    end
    step(); step();
    tests++; if (rspv[2] !== 1'b0) begin fails++; $display("FAIL b2b_extra_rsp: valid=%b want 0", rspv[2]); end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      rv[d] = 1'b0; rw[d] = 1'b0; ra[d] = '0; rwd[d] = '0; rr[d] = 1'b1;
    end
    test_reset();
    test_write_read();
    test_backpressure();
    test_latency0();
    test_out_of_range();
    test_reset_in_wait();
    test_reset_in_resp();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
